// File: rtl/clarvi_csr_pkg.sv
// Shared CSR definitions for the Clarvi machine-mode CSR file: op encoding,
// CSR addresses, mstatus bit positions and small address/value helpers.
package clarvi_csr_pkg;

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } csr_op_t;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  function automatic logic csr_addr_read_only(input logic [11:0] addr);
    return (addr[11:10] == 2'b11);
  endfunction

  function automatic logic csr_addr_exists(input logic [11:0] addr);
    logic hit;
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MCYCLE, CSR_MINSTRET, CSR_CYCLE, CSR_INSTRET,
      CSR_MHARTID: hit = 1'b1;
      default:     hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [63:0] csr_new_value(input csr_op_t op, input logic [63:0] old,
                                                input logic [63:0] src);
    logic [63:0] nv;
    case (op)
      CSR_RW:  nv = src;
      CSR_RS:  nv = old | src;
      CSR_RC:  nv = old & ~src;
      default: nv = old;
    endcase
    return nv;
  endfunction

endpackage

// File: rtl/clarvi_csr_counter.sv
// 64-bit free-running counter with a synchronous load that overrides the
// increment in the same cycle; wraps naturally at 2^64.
module clarvi_csr_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  input  logic        load,
  input  logic [63:0] load_value,
  output logic [63:0] value
);

  // Counter state: reset, then load, then increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      value <= 64'd0;
    end else if (load) begin
      value <= load_value;
    end else if (inc) begin
      value <= value + 64'd1;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/clarvi_csr_file.sv
// Machine-mode CSR file for the RV64 Clarvi core: zero-latency reads,
// writeback-stage read-modify-write commits, counters, trap entry and mret.
module clarvi_csr_file
  import clarvi_csr_pkg::*;
#(
  parameter logic [63:0] HART_ID    = 64'd0,
  parameter logic [63:0] MISA_VALUE = 64'h8000_0000_0000_0100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] csr_raddr,
  output logic [63:0] csr_rdata,
  output logic        csr_access_illegal,
  input  logic        csr_req,
  input  csr_op_t     csr_op,
  input  logic [11:0] csr_waddr,
  input  logic [63:0] csr_wsrc,
  input  logic        csr_src_is_zero,
  input  logic        instr_retire,
  input  logic        trap_take,
  input  logic [63:0] trap_pc,
  input  logic [63:0] trap_cause,
  input  logic [63:0] trap_tval,
  input  logic        mret_take,
  output logic [63:0] trap_vector,
  output logic [63:0] epc,
  output logic        mie_out
);

  logic        mie_r;
  logic        mpie_r;
  logic [63:0] mtvec_r;
  logic [63:0] mscratch_r;
  logic [63:0] mepc_r;
  logic [63:0] mcause_r;
  logic [63:0] mtval_r;
  logic [63:0] mcycle_s;
  logic [63:0] minstret_s;
  logic [63:0] mstatus_s;
  logic [63:0] wold_s;
  logic [63:0] wnew_s;
  logic        write_intent_s;
  logic        commit_en_s;
  logic        mcycle_load_s;
  logic        minstret_load_s;

  assign mstatus_s = {56'd0, mpie_r, 3'd0, mie_r, 3'd0};

  function automatic logic [63:0] csr_read(input logic [11:0] addr);
    logic [63:0] v;
    case (addr)
      CSR_MSTATUS:              v = mstatus_s;
      CSR_MISA:                 v = MISA_VALUE;
      CSR_MTVEC:                v = mtvec_r;
      CSR_MSCRATCH:             v = mscratch_r;
      CSR_MEPC:                 v = mepc_r;
      CSR_MCAUSE:               v = mcause_r;
      CSR_MTVAL:                v = mtval_r;
      CSR_MCYCLE, CSR_CYCLE:    v = mcycle_s;
      CSR_MINSTRET, CSR_INSTRET: v = minstret_s;
      CSR_MHARTID:              v = HART_ID;
      default:                  v = 64'd0;
    endcase
    return v;
  endfunction

  // misa is constant even though its address is in the writable range.
  function automatic logic csr_illegal(input logic [11:0] addr, input logic intent);
    return !csr_addr_exists(addr) ||
           (intent && (csr_addr_read_only(addr) || (addr == CSR_MISA)));
  endfunction

  // Read port, write intent and commit qualification.
  always_comb begin
    csr_rdata          = csr_read(csr_raddr);
    wold_s             = csr_read(csr_waddr);
    write_intent_s     = (csr_op == CSR_RW) ||
                         (((csr_op == CSR_RS) || (csr_op == CSR_RC)) && !csr_src_is_zero);
    csr_access_illegal = csr_illegal(csr_raddr, write_intent_s);
    wnew_s             = csr_new_value(csr_op, wold_s, csr_wsrc);
    if (csr_req && !trap_take && !mret_take && write_intent_s &&
        !csr_illegal(csr_waddr, write_intent_s)) begin
      commit_en_s = 1'b1;
    end else begin
      commit_en_s = 1'b0;
    end
    mcycle_load_s   = commit_en_s && (csr_waddr == CSR_MCYCLE);
    minstret_load_s = commit_en_s && (csr_waddr == CSR_MINSTRET);
  end

  clarvi_csr_counter u_mcycle (
    .clock      (clock),
    .reset      (reset),
    .inc        (1'b1),
    .load       (mcycle_load_s),
    .load_value (wnew_s),
    .value      (mcycle_s)
  );

  clarvi_csr_counter u_minstret (
    .clock      (clock),
    .reset      (reset),
    .inc        (instr_retire),
    .load       (minstret_load_s),
    .load_value (wnew_s),
    .value      (minstret_s)
  );

  // Architectural state: reset > trap entry > mret > CSR commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      mie_r      <= 1'b0;
      mpie_r     <= 1'b0;
      mtvec_r    <= 64'd0;
      mscratch_r <= 64'd0;
      mepc_r     <= 64'd0;
      mcause_r   <= 64'd0;
      mtval_r    <= 64'd0;
    end else if (trap_take) begin
      mepc_r   <= trap_pc & ~64'd3;
      mcause_r <= trap_cause;
      mtval_r  <= trap_tval;
      mpie_r   <= mie_r;
      mie_r    <= 1'b0;
    end else if (mret_take) begin
      mie_r  <= mpie_r;
      mpie_r <= 1'b1;
    end else if (commit_en_s) begin
      case (csr_waddr)
        CSR_MSTATUS: begin
          mie_r  <= wnew_s[MSTATUS_MIE_BIT];
          mpie_r <= wnew_s[MSTATUS_MPIE_BIT];
        end
        CSR_MTVEC:    mtvec_r    <= wnew_s & ~64'd3;
        CSR_MSCRATCH: mscratch_r <= wnew_s;
        CSR_MEPC:     mepc_r     <= wnew_s & ~64'd3;
        CSR_MCAUSE:   mcause_r   <= wnew_s;
        CSR_MTVAL:    mtval_r    <= wnew_s;
        default:      mscratch_r <= mscratch_r;
      endcase
    end else begin
      mie_r <= mie_r;
    end
  end

  assign trap_vector = mtvec_r;
  assign epc         = mepc_r;
  assign mie_out     = mie_r;

endmodule
